seq_addsub_n: RTL and testbench



---
 rtl/seq_addsub_n_if.sv | 29 ++
 rtl/seq_addsub_n.sv | 127 ++++++++++++
 tb/tb_seq_addsub_n.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seq_addsub_n_if.sv
// seq_addsub_n_if: operand/result bundle for the digit-serial add/subtract unit.
//   start, mode, a, b, bin : request side (driven by the master)
//   busy, done, result,
//   cout, ovf              : status/result side (driven by the unit)
// W must match the W of the seq_addsub_n instance it is connected to.
interface seq_addsub_n_if #(
    parameter int W = 32
);
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output start, mode, a, b, bin,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, mode, a, b, bin,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/seq_addsub_n.sv
// seq_addsub_n: digit-serial add/subtract unit, D bits per clock over N=W/D cycles.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : seq_addsub_n_if.slave
//         start/mode/a/b/bin sampled in IDLE only (mode 1 = add, 0 = subtract)
//         busy high while running, done one-cycle pulse N cycles after accept,
//         result/cout/ovf valid at done and held until the next accepted start
module seq_addsub_n #(
    parameter int W = 32,
    parameter int D = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_addsub_n_if.slave bus
);
    localparam int N  = W / D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          mode_q, mode_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  result_q, result_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [D-1:0]  a_dig, b_dig;
    logic [D:0]    dig_w;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        a_dig = a_q[int'(cnt_q) * D +: D];
        b_dig = b_q[int'(cnt_q) * D +: D];
        // Bit D of the (D+1)-bit add is the carry; for subtract it goes high
        // exactly when the digit difference is negative, i.e. the borrow.
        if (mode_q) begin
            dig_w = {1'b0, a_dig} + {1'b0, b_dig} + {{D{1'b0}}, carry_q};
        end else begin
            dig_w = {1'b0, a_dig} - {1'b0, b_dig} - {{D{1'b0}}, carry_q};
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    mode_d  = bus.mode;
                    carry_d = bus.bin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[int'(cnt_q) * D +: D] = dig_w[D-1:0];
                carry_d = dig_w[D];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cout_d  = dig_w[D];
                    // MSB digit is written this cycle, so use result_d.
                    if (mode_q) begin
                        ovf_d = (a_q[W-1] == b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
                    end else begin
                        ovf_d = (a_q[W-1] != b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_seq_addsub_n.sv
module tb_seq_addsub_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [2:0] sweep_fin = '0;

    always #5 clk = ~clk;

    seq_addsub_n_if #(.W(32)) m ();
    seq_addsub_n #(.W(32), .D(8)) dut (.clk(clk), .rst(rst), .bus(m.slave));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then range tests for flags.
    function automatic logic [33:0] golden(input logic md, input logic [31:0] x,
                                           input logic [31:0] y, input logic ci);
        longint ux, uy, sx, sy, u, s;
        logic co, ov;
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (md) begin
            u = ux + uy + longint'(ci);
            s = sx + sy + longint'(ci);
            co = (u >= 64'sd4294967296);
        end else begin
            u = ux - uy - longint'(ci);
            s = sx - sy - longint'(ci);
            co = (u < 0);
        end
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {co, ov, u[31:0]};
    endfunction

    task automatic drive_start(input logic md, input logic [31:0] x, input logic [31:0] y,
                               input logic ci);
        m.start = 1'b1; m.mode = md; m.a = x; m.b = y; m.bin = ci;
        @(posedge clk); #1;
        m.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int first, output int lat);
        lat = first;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (m.done) return;
            check({nm, "/busy"}, m.busy, 1'b1);
            if (lat > 12) return;
        end
    endtask

    task automatic run_op(input string nm, input logic md, input logic [31:0] x,
                          input logic [31:0] y, input logic ci, input logic [33:0] exp);
        int lat;
        drive_start(md, x, y, ci);
        check({nm, "/busy_k"}, m.busy, 1'b1);
        wait_done(nm, 0, lat);
        check({nm, "/lat"}, lat, 4);
        check({nm, "/res"}, {m.cout, m.ovf, m.result}, exp);
        check({nm, "/busy_done"}, m.busy, 1'b0);
    endtask

    typedef struct {
        string       nm;
        logic        md;
        logic [31:0] x;
        logic [31:0] y;
        logic        ci;
        logic [31:0] r;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat;
        vecs[0] = '{"sub5m3",    1'b0, 32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{"sub0m1",    1'b0, 32'h0,          32'h1,          1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2] = '{"subminm1",  1'b0, 32'h8000_0000,  32'h1,          1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{"addffp1",   1'b1, 32'hFFFF_FFFF,  32'h1,          1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{"addmaxp1",  1'b1, 32'h7FFF_FFFF,  32'h1,          1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[5] = '{"addcarry",  1'b1, 32'h0000_00FF,  32'h1,          1'b1, 32'h0000_0101, 1'b0, 1'b0};
        vecs[6] = '{"subbin",    1'b0, 32'd10,         32'd4,          1'b1, 32'd5,         1'b0, 1'b0};

        m.start = 1'b0; m.mode = 1'b0; m.a = '0; m.b = '0; m.bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_s = 1'b0;
        check("reset_state", {m.busy, m.done, m.cout, m.ovf, m.result}, '0);

        // Table vectors, issued back-to-back (each start lands in the prior done cycle).
        for (int unsigned i = 0; i < 7; i++) begin
            run_op(vecs[i].nm, vecs[i].md, vecs[i].x, vecs[i].y, vecs[i].ci,
                   {vecs[i].co, vecs[i].ov, vecs[i].r});
        end

        // start re-asserted mid-operation with different operands is ignored.
        drive_start(1'b1, 32'h0000_1000, 32'h0000_0234, 1'b0);
        m.start = 1'b1; m.mode = 1'b0; m.a = 32'hDEAD_BEEF; m.b = 32'h1; m.bin = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m.start = 1'b0;
        wait_done("ignore", 2, lat);
        check("ignore/lat", lat, 4);
        check("ignore/res", {m.cout, m.ovf, m.result}, {2'b00, 32'h0000_1234});

        // Reset mid-operation, with start asserted at the reset edge.
        drive_start(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; m.start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m.start = 1'b0;
        check("rst/outs", {m.busy, m.done, m.cout, m.ovf, m.result}, '0);
        for (int unsigned c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("rst/no_done", {m.busy, m.done}, 2'b00);
        end
        run_op("after_rst", 1'b0, 32'd10, 32'd4, 1'b0, {2'b00, 32'd6});

        // Wait for the parameter sweeps, bounded.
        for (int c = 0; c < 60000 && sweep_fin != 3'b111; c++) @(posedge clk);
        check("sweep_complete", sweep_fin, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Random sweep over D = 1, 4, 32 against the reference model.
    for (genvar g = 0; g < 3; g++) begin : sweep
        localparam int DG = (g == 0) ? 1 : (g == 1) ? 4 : 32;
        localparam int NG = 32 / DG;

        seq_addsub_n_if #(.W(32)) s_if ();
        seq_addsub_n #(.W(32), .D(DG)) s_dut (.clk(clk), .rst(rst_s), .bus(s_if.slave));

        initial begin
            logic        md, ci;
            logic [31:0] x, y;
            int          lat;
            s_if.start = 1'b0; s_if.mode = 1'b0; s_if.a = '0; s_if.b = '0; s_if.bin = 1'b0;
            wait (rst_s == 1'b0);
            for (int unsigned i = 0; i < 1000; i++) begin
                x  = $urandom;
                y  = $urandom;
                md = 1'($urandom_range(0, 1));
                ci = 1'($urandom_range(0, 1));
                case (i % 16)
                    0: x = 32'hFFFF_FFFF;
                    1: y = 32'hFFFF_FFFF;
                    2: x = 32'h8000_0000;
                    3: y = 32'h7FFF_FFFF;
                    4: y = x;
                    default: ;
                endcase
                s_if.start = 1'b1; s_if.mode = md; s_if.a = x; s_if.b = y; s_if.bin = ci;
                @(posedge clk); #1;
                // Scramble inputs while busy; they must not affect the result.
                s_if.start = 1'b0; s_if.a = $urandom; s_if.b = $urandom; s_if.mode = ~md;
                lat = 0;
                while (!s_if.done && lat < NG + 5) begin
                    @(posedge clk); #1;
                    lat++;
                end
                check($sformatf("sweepD%0d/lat", DG), lat, NG);
                check($sformatf("sweepD%0d/res", DG),
                      {s_if.cout, s_if.ovf, s_if.result}, golden(md, x, y, ci));
            end
            sweep_fin[g] = 1'b1;
        end
    end
endmodule
